// File: rtl/sign_xtend_pipe.sv
// Sign/zero extension stage with a 2-entry result FIFO and valid/ready handshakes.
// Extension happens at accept time, so only OUT_W-wide results are buffered.
module sign_xtend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [IN_W-1:0]  DATA_IN,
    input  logic [1:0]       MODE,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [OUT_W-1:0] DATA_OUT,
    output logic [1:0]       COUNT
);

    generate
        if (IN_W < 8 || IN_W > OUT_W) begin : g_param_err
            $error("sign_xtend_pipe: IN_W must be in 8..OUT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             state_q;
    occ_t             state_d;
    logic [OUT_W-1:0] mem [0:1];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [OUT_W-1:0] ext_result;
    logic [OUT_W-1:0] din_wide;
    logic             fill_bit;
    int               src_w;

    assign do_push = IN_VALID && IN_READY;
    assign do_pop  = OUT_VALID && OUT_READY;

    // Bits below the source width come from the operand; everything above is the fill bit.
    always_comb begin
        din_wide = OUT_W'(DATA_IN);
        src_w    = MODE[1] ? 8 : IN_W;
        fill_bit = 1'b0;
        if (!MODE[0]) begin
            fill_bit = MODE[1] ? DATA_IN[7] : DATA_IN[IN_W-1];
        end
        ext_result = '0;
        for (int i = 0; i < OUT_W; i++) begin
            ext_result[i] = (i < src_w) ? din_wide[i] : fill_bit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (do_push) state_d = ONE;
            end
            ONE: begin
                if (do_push && !do_pop)      state_d = FULL;
                else if (do_pop && !do_push) state_d = EMPTY;
            end
            FULL: begin
                if (do_pop) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        OUT_VALID = (state_q != EMPTY);
        IN_READY  = (state_q != FULL) && reset;
        COUNT     = state_q;
        DATA_OUT  = (state_q == EMPTY) ? '0 : mem[rd_ptr];
    end

    // Storage and pointers; a simultaneous push and pop in ONE leaves the new entry at the head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= ext_result;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

endmodule

// File: tb/tb_sign_xtend_pipe.sv
// Self-checking bench for sign_xtend_pipe: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_sign_xtend_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_in;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [1:0]  count;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [7:0]  w_data_in;
    logic        w_out_valid;
    logic [63:0] w_data_out;
    logic [1:0]  w_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_q[$];

    sign_xtend_pipe dut (
        .clk(clk), .reset(rst_n),
        .IN_VALID(in_valid), .IN_READY(in_ready), .DATA_IN(data_in), .MODE(mode),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .DATA_OUT(data_out), .COUNT(count)
    );

    sign_xtend_pipe #(.IN_W(8), .OUT_W(64)) dut_wide (
        .clk(clk), .reset(rst_n),
        .IN_VALID(w_in_valid), .IN_READY(w_in_ready), .DATA_IN(w_data_in), .MODE(2'b00),
        .OUT_VALID(w_out_valid), .OUT_READY(1'b0), .DATA_OUT(w_data_out), .COUNT(w_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] extModel(input logic [15:0] d, input logic [1:0] m);
        logic signed [15:0] s16;
        logic signed [7:0]  s8;
        logic [7:0]         lo;
        lo  = d[7:0];
        s16 = d;
        s8  = lo;
        case (m)
            2'b00:   return 32'(s16);
            2'b01:   return 32'(d);
            2'b10:   return 32'(s8);
            default: return 32'(lo);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: FIFO occupancy and contents from the handshake rules alone.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else begin
            automatic bit acc = in_valid && (model_q.size() < 2);
            automatic bit pop = out_ready && (model_q.size() > 0);
            if (pop) void'(model_q.pop_front());
            if (acc) model_q.push_back(extModel(data_in, mode));
        end
    end

    always @(negedge clk) begin
        checkOutput("model_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
        checkOutput("model_count", 64'(count), 64'(model_q.size()));
        checkOutput("model_in_ready", 64'(in_ready), 64'((model_q.size() < 2) && rst_n));
        checkOutput("model_data_out", 64'(data_out), (model_q.size() != 0) ? 64'(model_q[0]) : 64'd0);
    end

    task automatic applyStimulus(input logic [15:0] d, input logic [1:0] m);
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        data_in  = d;
        mode     = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        data_in    = '0;
        mode       = 2'b00;
        out_ready  = 1'b1;
        w_in_valid = 1'b0;
        w_data_in  = '0;
        #2;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_data_out", 64'(data_out), 64'd0);
        checkOutput("reset_count", 64'(count), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("post_reset_out_valid", 64'(out_valid), 64'd0);

        // Wide instance: 8-bit operand sign-extended to 64 bits
        @(negedge clk);
        #1;
        w_in_valid = 1'b1;
        w_data_in  = 8'h80;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        checkOutput("wide_valid", 64'(w_out_valid), 64'd1);
        checkOutput("wide_data", w_data_out, 64'hFFFFFFFFFFFFFF80);

        applyStimulus(16'h8001, 2'b00);
        checkOutput("sext16", 64'(data_out), 64'hFFFF8001);
        checkOutput("sext16_valid", 64'(out_valid), 64'd1);
        applyStimulus(16'h8001, 2'b01);
        checkOutput("zext16", 64'(data_out), 64'h00008001);
        applyStimulus(16'h12F0, 2'b10);
        checkOutput("sext8_neg", 64'(data_out), 64'hFFFFFFF0);
        applyStimulus(16'h12F0, 2'b11);
        checkOutput("zext8", 64'(data_out), 64'h000000F0);
        applyStimulus(16'hFF7F, 2'b10);
        checkOutput("sext8_pos", 64'(data_out), 64'h0000007F);
        @(posedge clk);
        #1;
        checkOutput("drain_valid", 64'(out_valid), 64'd0);
        checkOutput("drain_data", 64'(data_out), 64'd0);

        // Fill with consumer stalled, try a third push, then drain
        out_ready = 1'b0;
        applyStimulus(16'h0001, 2'b00);
        applyStimulus(16'hFFFF, 2'b00);
        checkOutput("full_count", 64'(count), 64'd2);
        checkOutput("full_in_ready", 64'(in_ready), 64'd0);
        applyStimulus(16'h1234, 2'b01);
        checkOutput("full_ignore_count", 64'(count), 64'd2);
        checkOutput("stall_head", 64'(data_out), 64'h00000001);
        @(negedge clk);
        #1;
        out_ready = 1'b1;
        checkOutput("pop_first", 64'(data_out), 64'h00000001);
        @(posedge clk);
        #1;
        checkOutput("pop_second", 64'(data_out), 64'hFFFFFFFF);
        @(posedge clk);
        #1;
        checkOutput("pop_empty_valid", 64'(out_valid), 64'd0);
        checkOutput("pop_empty_data", 64'(data_out), 64'd0);

        // Steady state at COUNT=1 with push and pop on every edge
        out_ready = 1'b0;
        applyStimulus(16'hA5A5, 2'b00);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            automatic logic [15:0] d = 16'h8080 + 16'(i * 16'h0111);
            automatic logic [1:0]  m = 2'(i % 4);
            applyStimulus(d, m);
            checkOutput("xfer_count", 64'(count), 64'd1);
            checkOutput("xfer_head", 64'(data_out), 64'(extModel(d, m)));
        end
        @(posedge clk);
        #1;
        checkOutput("xfer_drained", 64'(count), 64'd0);

        // Asynchronous reset while full
        out_ready = 1'b0;
        applyStimulus(16'h1111, 2'b00);
        applyStimulus(16'h2222, 2'b00);
        checkOutput("prereset_count", 64'(count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", 64'(out_valid), 64'd0);
        checkOutput("async_in_ready", 64'(in_ready), 64'd0);
        checkOutput("async_count", 64'(count), 64'd0);
        checkOutput("async_data", 64'(data_out), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(16'h0005, 2'b01);
        checkOutput("after_reset_head", 64'(data_out), 64'h00000005);
        checkOutput("after_reset_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sign_xtend_pipe.md
SIGN_XTEND_PIPE -- requirements
Module: sign_xtend_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16: width of DATA_IN; legal range 8..OUT_W.
REQ-002 SHALL have parameter OUT_W, default 32: width of DATA_OUT; SHALL be >= IN_W.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port IN_VALID, input, 1: producer has an operand on DATA_IN/MODE.
REQ-006 SHALL have port IN_READY, output, 1: block can accept an operand this cycle.
REQ-007 SHALL have port DATA_IN, input, IN_W: raw operand.
REQ-008 SHALL have port MODE, input, 2: extension mode, sampled with DATA_IN.
REQ-009 SHALL have port OUT_VALID, output, 1: DATA_OUT holds a valid extended result.
REQ-010 SHALL have port OUT_READY, input, 1: consumer takes DATA_OUT this cycle.
REQ-011 SHALL have port DATA_OUT, output, OUT_W: extended result at the buffer head.
REQ-012 SHALL have port COUNT, output, 2: number of buffered results (0..2).

Function
REQ-013 Extension SHALL follow MODE: 00 = sign-extend all IN_W bits; 01 = zero-extend all IN_W bits; 10 = sign-extend DATA_IN[7:0]; 11 = zero-extend DATA_IN[7:0].
REQ-014 Sign extension SHALL replicate the source MSB (bit IN_W-1 or bit 7) into every higher bit of the OUT_W result. Zero extension SHALL fill those bits with 0.
REQ-015 In byte modes, DATA_IN bits above 7 SHALL be ignored.
REQ-016 Extension SHALL be computed at accept time, and the OUT_W result SHALL be stored in a 2-entry FIFO. Raw operands SHALL NOT be stored.
REQ-017 Accept SHALL occur on a rising edge where IN_VALID && IN_READY. Pop SHALL occur on a rising edge where OUT_VALID && OUT_READY.
REQ-018 IN_READY SHALL equal (COUNT < 2) && reset deasserted. It SHALL be low when full, even if a pop occurs in the same cycle; there is no full-buffer pass-through.
REQ-019 OUT_VALID SHALL equal (COUNT != 0).
REQ-020 Latency SHALL be 1 cycle: an operand accepted at edge N is visible on DATA_OUT with OUT_VALID=1 immediately after edge N when the buffer was empty. There is no combinational in-to-out path.
REQ-021 Occupancy states SHALL be EMPTY(0), ONE(1) and FULL(2), with these transitions:
- EMPTY: accept -> ONE.
- ONE: accept without pop -> FULL; pop without accept -> EMPTY; accept with pop -> ONE, and the new result becomes the head after the edge.
- FULL: pop -> ONE; accept is impossible.
REQ-022 Results SHALL leave in acceptance order. Read and write pointers SHALL wrap modulo 2.
REQ-023 DATA_OUT SHALL be all-zero whenever COUNT = 0.
REQ-024 DATA_OUT and OUT_VALID SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-025 IN_VALID while IN_READY=0 SHALL be ignored, with no state change. OUT_READY while OUT_VALID=0 SHALL be ignored.
REQ-026 Parameter values violating REQ-001 or REQ-002 SHALL cause an elaboration-time error.

Reset
REQ-027 reset low SHALL immediately, without waiting for a clock edge, force COUNT=0, both pointers=0, OUT_VALID=0, IN_READY=0 and DATA_OUT=0.
REQ-028 reset low mid-operation SHALL discard all buffered results. No partial accept or pop SHALL be recorded at an edge coinciding with reset low.
REQ-029 On the first rising edge after reset goes high, IN_READY SHALL be 1 and no output SHALL be valid.

Verification
REQ-030 Defaults, MODE=00, DATA_IN=16'h8001, OUT_READY=1 -> next cycle DATA_OUT=32'hFFFF8001, OUT_VALID=1; MODE=01 with same data -> 32'h00008001.
REQ-031 MODE=10, DATA_IN=16'h12F0 -> 32'hFFFFFFF0; MODE=11, DATA_IN=16'h12F0 -> 32'h000000F0; MODE=10, DATA_IN=16'hFF7F -> 32'h0000007F.
REQ-032 OUT_READY=0, push 16'h0001 then 16'hFFFF (MODE=00) -> COUNT=2, IN_READY=0, a third push is ignored; then OUT_READY=1 -> outputs 32'h00000001, then 32'hFFFFFFFF, then OUT_VALID=0 with DATA_OUT=0.
REQ-033 COUNT=1, simultaneous accept and pop each cycle for 8 cycles with alternating MODE -> COUNT stays 1, order preserved, pointers wrap without loss.
REQ-034 COUNT=2, assert reset low between edges -> OUT_VALID, IN_READY, COUNT and DATA_OUT go to 0 before the next edge; after release, the first new push appears as the head.
REQ-035 IN_W=8, OUT_W=64, MODE=00, DATA_IN=8'h80 -> 64'hFFFFFFFFFFFFFF80; illegal IN_W=4 -> elaboration fails.
